axi_sram_slave: RTL and testbench

//  AXI4 burst slave backing the single port of the IFU/LSU arbiter: models main memory as a 64-bit-wide SRAM.

---
 rtl/axi_sram_pkg.sv | 58 +++++
 rtl/axi_burst_addr_gen.sv | 49 ++++
 rtl/axi_sram_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_pkg
// Purpose  : Shared definitions for the AXI4 SRAM slave: burst encodings,
//            response codes, FSM state enum and small burst helper functions.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package axi_sram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_R_DATA = 2'd1,
        ST_W_DATA = 2'd2,
        ST_W_RESP = 2'd3
    } state_e;

    // Bytes per beat; illegal sizes are clamped to the bus width so the
    // address still advances sanely while the burst reports SLVERR.
    function automatic logic [7:0] beat_bytes(input logic [2:0] size);
        if (size > 3'd3) begin
            return 8'd8;
        end
        return 8'd1 << size;
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Burst-level configuration error (independent of the beat address).
    function automatic logic burst_cfg_err(input logic [1:0] burst,
                                           input logic [7:0] len,
                                           input logic [2:0] size);
        return (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok(len)) ||
               (size > 3'd3);
    endfunction

    // Response codes are ordered so that the numerically larger one is worse.
    function automatic logic [1:0] worst_resp(input logic [1:0] a,
                                              input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Purpose  : Combinational next-beat address for FIXED / INCR / WRAP bursts.
//            Reserved bursts hold the address; WRAP with an illegal length
//            advances like INCR (the burst is flagged SLVERR elsewhere).
// Ports    : addr      in  32  current beat byte address
//            burst     in   2  burst type
//            len       in   8  beats-1
//            size      in   3  log2 bytes per beat
//            next_addr out 32  address of the following beat
// Revision : 1.0  initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_sram_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  burst,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    assign step      = {24'd0, beat_bytes(size)};
    assign incr_addr = addr + step;
    // Window is (len+1)*bytes, a power of two for every legal WRAP length.
    assign wrap_mask = (({24'd0, len} + 32'd1) * step) - 32'd1;

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end else begin
                    next_addr = incr_addr;
                end
            end
            default: next_addr = addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Purpose  : AXI4 burst slave modelling main memory as a 64-bit SRAM. Serves
//            one transaction at a time (read wins over write in IDLE), FIXED /
//            INCR / WRAP bursts, byte-strobed writes, OKAY/SLVERR/DECERR.
// Config   : AXI_SRAM_DELAY_EN - LFSR-driven 0..3 cycle wait states before
//            address acceptance and before each R / W beat.
// Ports    : clk, rst (async active-low)
//            AR: araddr, arvalid, arburst, arlen, arsize -> arready
//            R : rdata, rresp, rvalid, rlast <- rready
//            AW: awaddr, awvalid, awburst, awlen -> awready (8-byte beats)
//            W : wdata, wlast, wstrb, wvalid -> wready
//            B : bresp, bvalid <- bready
// Revision : 1.0  initial release
// ============================================================================
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [7:0]  DELAY_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [1:0]  awburst,
    input  logic [7:0]  awlen,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic        wlast,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(8 * MEM_WORDS);

    logic [63:0] mem [MEM_WORDS];

    state_e      state;
    state_e      state_nxt;
    logic        ready_en;   // keeps every output low until the first clock after reset
    logic        wait_ok;
    logic        go;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;
    logic [7:0]  beat;
    logic        cfg_err;
    logic [31:0] nxt_addr;
    logic        last_beat;
    logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic        ar_cfg_err, aw_cfg_err;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && (off < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IDX_W+2:3];
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic err);
        if (!in_range(a)) begin
            return RESP_DECERR;
        end
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    axi_burst_addr_gen u_addr_gen (
        .addr      (cur_addr),
        .burst     (cur_burst),
        .len       (cur_len),
        .size      (cur_size),
        .next_addr (nxt_addr)
    );

`ifdef AXI_SRAM_DELAY_EN
    logic [7:0] lfsr;
    logic [1:0] wait_cnt;
    logic       reload;

    // Every accepted handshake starts a fresh wait before the next one.
    assign reload = ar_hs | aw_hs | r_hs | w_hs | b_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= DELAY_SEED;
            wait_cnt <= DELAY_SEED[1:0];
        end else begin
            // Galois LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
            if (reload) begin
                wait_cnt <= lfsr[1:0];
            end else if (wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    assign wait_ok = (wait_cnt == 2'd0);
`else
    assign wait_ok = 1'b1;
`endif

    assign go         = ready_en & wait_ok;
    assign last_beat  = (beat == cur_len);
    assign ar_hs      = (state == ST_IDLE) && go && arvalid;
    assign aw_hs      = (state == ST_IDLE) && go && awvalid && !arvalid;
    assign r_hs       = (state == ST_R_DATA) && go && rready;
    assign w_hs       = (state == ST_W_DATA) && go && wvalid;
    assign b_hs       = (state == ST_W_RESP) && bready;
    assign ar_cfg_err = burst_cfg_err(arburst, arlen, arsize);
    assign aw_cfg_err = burst_cfg_err(awburst, awlen, 3'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (state)
            ST_IDLE: begin
                arready = go;
                awready = go;
                if (ar_hs) begin
                    state_nxt = ST_R_DATA;
                end else if (aw_hs) begin
                    state_nxt = ST_W_DATA;
                end
            end
            ST_R_DATA: begin
                rvalid = go;
                rlast  = last_beat;
                if (r_hs && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_W_DATA: begin
                wready = go;
                // Beat count, not wlast, ends the burst.
                if (w_hs && last_beat) begin
                    state_nxt = ST_W_RESP;
                end
            end
            ST_W_RESP: begin
                bvalid = 1'b1;
                if (b_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst context and registered read data. The array read for beat n+1 is
    // issued on the beat-n handshake so data is ready the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr  <= 32'd0;
            cur_len   <= 8'd0;
            cur_size  <= 3'd0;
            cur_burst <= 2'd0;
            beat      <= 8'd0;
            cfg_err   <= 1'b0;
            rdata     <= 64'd0;
            rresp     <= RESP_OKAY;
            bresp     <= RESP_OKAY;
        end else if (ar_hs) begin
            cur_addr  <= araddr;
            cur_len   <= arlen;
            cur_size  <= arsize;
            cur_burst <= arburst;
            beat      <= 8'd0;
            cfg_err   <= ar_cfg_err;
            rdata     <= in_range(araddr) ? mem[word_idx(araddr)] : 64'd0;
            rresp     <= beat_resp(araddr, ar_cfg_err);
        end else if (aw_hs) begin
            cur_addr  <= awaddr;
            cur_len   <= awlen;
            cur_size  <= 3'd3;
            cur_burst <= awburst;
            beat      <= 8'd0;
            cfg_err   <= aw_cfg_err;
            bresp     <= aw_cfg_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs && !last_beat) begin
            cur_addr  <= nxt_addr;
            beat      <= beat + 8'd1;
            rdata     <= in_range(nxt_addr) ? mem[word_idx(nxt_addr)] : 64'd0;
            rresp     <= beat_resp(nxt_addr, cfg_err);
        end else if (w_hs) begin
            cur_addr  <= nxt_addr;
            beat      <= beat + 8'd1;
            bresp     <= worst_resp(worst_resp(bresp, beat_resp(cur_addr, cfg_err)),
                                    (wlast != last_beat) ? RESP_SLVERR : RESP_OKAY);
        end
    end

    // Memory contents survive reset; out-of-range beats are dropped.
    always_ff @(posedge clk) begin
        if (w_hs && in_range(cur_addr)) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx(cur_addr)][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Purpose  : Self-checking bench for axi_sram_slave. A word-array reference
//            memory plus arithmetic beat-address / response rules predict
//            every R beat and B response for directed and random bursts.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;
    logic [63:0] wdata;
    logic        wlast;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] model [WORDS];

    always #5 clk = ~clk;

    axi_sram_slave #(
        .ADDR_BASE  (BASE),
        .MEM_WORDS  (WORDS),
        .DELAY_SEED (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arburst (arburst),
        .arlen   (arlen),
        .arsize  (arsize),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awburst (awburst),
        .awlen   (awlen),
        .awready (awready),
        .wdata   (wdata),
        .wlast   (wlast),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic bit ref_in_range(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 8 * WORDS);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic bit ref_cfg_err(input logic [1:0] b, input logic [7:0] l, input logic [2:0] s);
        bit wrap_ok;
        wrap_ok = (l == 1) || (l == 3) || (l == 7) || (l == 15);
        return (b == 2'd3) || (b == 2'd2 && !wrap_ok) || (s > 3);
    endfunction

    function automatic logic [31:0] ref_beat_addr(input logic [31:0] a, input logic [1:0] b,
                                                  input logic [7:0] l, input logic [2:0] s,
                                                  input int n);
        longint bytes, win, base_a, start;
        bytes = (s > 3) ? 8 : (longint'(1) << s);
        start = longint'(a);
        if (b == 2'd1) return 32'(start + n * bytes);
        if (b == 2'd2) begin
            if ((l == 1) || (l == 3) || (l == 7) || (l == 15)) begin
                win    = (longint'(l) + 1) * bytes;
                base_a = (start / win) * win;
                return 32'(base_a + ((start - base_a) + n * bytes) % win);
            end
            return 32'(start + n * bytes);
        end
        return a;
    endfunction

    function automatic logic [1:0] ref_resp(input logic [31:0] a, input bit cfg);
        if (!ref_in_range(a)) return 2'b11;
        return cfg ? 2'b10 : 2'b00;
    endfunction

    task automatic all_zero(input string tag);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_rvalid"},  rvalid,  0);
        check({tag, "_rlast"},   rlast,   0);
        check({tag, "_rdata"},   rdata,   0);
        check({tag, "_rresp"},   rresp,   0);
        check({tag, "_wready"},  wready,  0);
        check({tag, "_bvalid"},  bvalid,  0);
        check({tag, "_bresp"},   bresp,   0);
    endtask

    // ---------------- read burst ----------------
    task automatic do_read(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                           input logic [2:0] s, input int stall_beat, input bit rnd_stall);
        int n, cyc, st;
        bit cfg, stall;
        logic [31:0] ba;
        cfg = ref_cfg_err(b, l, s);
        araddr = a; arburst = b; arlen = l; arsize = s; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 100) begin @(negedge clk); cyc++; end
        if (!arready) check("ar_accept_timeout", 0, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_first_beat_latency", rvalid, 1);
        n = 0; cyc = 0; st = 0;
        while (n <= int'(l) && cyc < 3000) begin
            stall = 1'b0;
            if (n == stall_beat && st < 3) begin stall = 1'b1; st++; end
            if (rnd_stall && $urandom_range(0, 3) == 0) stall = 1'b1;
            rready = !stall;
            if (rvalid) begin
                ba = ref_beat_addr(a, b, l, s, n);
                check("rdata", rdata, ref_in_range(ba) ? model[ref_idx(ba)] : 64'd0);
                check("rresp", rresp, ref_resp(ba, cfg));
                check("rlast", rlast, n == int'(l));
                if (rready) n++;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (n <= int'(l)) check("r_burst_timeout", n, int'(l) + 1);
        check("idle_after_rlast", arready, 1);
    endtask

    // ---------------- write burst ----------------
    task automatic do_write(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                            input int wlast_beat, input bit rnd_gap, input bit use_fixed,
                            input logic [63:0] fdata, input logic [7:0] fstrb);
        int n, cyc;
        bit cfg;
        logic [1:0]  worst;
        logic [31:0] ba;
        logic [63:0] wd;
        logic [7:0]  ws;
        cfg   = ref_cfg_err(b, l, 3'd3);
        worst = cfg ? 2'b10 : 2'b00;
        if (wlast_beat != int'(l)) worst = 2'b10;
        awaddr = a; awburst = b; awlen = l; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 100) begin @(negedge clk); cyc++; end
        if (!awready) check("aw_accept_timeout", 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        n = 0; cyc = 0;
        wd = use_fixed ? fdata : {$urandom, $urandom};
        ws = use_fixed ? fstrb : 8'($urandom);
        while (n <= int'(l) && cyc < 3000) begin
            wvalid = !(rnd_gap && $urandom_range(0, 3) == 0);
            wdata  = wd;
            wstrb  = ws;
            wlast  = (n == wlast_beat);
            if (wvalid && wready) begin
                ba = ref_beat_addr(a, b, l, 3'd3, n);
                if (ref_in_range(ba)) begin
                    for (int i = 0; i < 8; i++)
                        if (ws[i]) model[ref_idx(ba)][8*i +: 8] = wd[8*i +: 8];
                end else begin
                    worst = 2'b11;
                end
                n++;
                wd = use_fixed ? fdata : {$urandom, $urandom};
                ws = use_fixed ? fstrb : 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (n <= int'(l)) check("w_burst_timeout", n, int'(l) + 1);
        cyc = 0;
        while (!bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        check("bvalid", bvalid, 1);
        check("bresp", bresp, worst);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("idle_after_b", awready, 1);
    endtask

    initial begin
        int rs, rl, sw;
        logic [1:0] rb;
        rst = 1'b0;
        araddr = '0; arvalid = 0; arburst = '0; arlen = '0; arsize = '0; rready = 0;
        awaddr = '0; awvalid = 0; awburst = '0; awlen = '0;
        wdata = '0; wlast = 0; wstrb = '0; wvalid = 0; bready = 0;
        #23;
        all_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("arready_after_reset", arready, 1);
        check("awready_after_reset", awready, 1);

        // Preload words 0..31 so every later in-range read is predictable.
        do_write(BASE, 2'd1, 8'd31, 31, 1'b0, 1'b0, 64'd0, 8'h00);
        // Top word of memory, for the end-of-range bursts.
        do_write(BASE + 32'h7FF8, 2'd1, 8'd1, 1, 1'b0, 1'b0, 64'd0, 8'h00);

        // Single beat read of word 2.
        do_read(32'h8000_0010, 2'd1, 8'd0, 3'd3, -1, 1'b0);
        // INCR write 4 words, read back with rready low for 3 cycles mid-burst.
        do_write(BASE, 2'd1, 8'd3, 3, 1'b0, 1'b0, 64'd0, 8'h00);
        do_read(BASE, 2'd1, 8'd3, 3'd3, 2, 1'b0);
        // WRAP starting at word 3: order 3,0,1,2.
        do_read(32'h8000_0018, 2'd2, 8'd3, 3'd3, -1, 1'b0);
        // Strobed write over a zeroed word 0.
        do_write(BASE, 2'd1, 8'd0, 0, 1'b0, 1'b1, 64'd0, 8'hFF);
        do_write(BASE, 2'd1, 8'd0, 0, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
        do_read(BASE, 2'd1, 8'd0, 3'd3, -1, 1'b0);
        check("strobed_word0_model", model[0], 64'h0000_0000_5566_7788);
        // Narrow INCR and FIXED bursts.
        do_read(32'h8000_0020, 2'd1, 8'd3, 3'd2, -1, 1'b1);
        do_read(32'h8000_0040, 2'd0, 8'd3, 3'd3, -1, 1'b0);
        // Error responses.
        do_read(32'h0000_1000, 2'd1, 8'd0, 3'd3, -1, 1'b0);
        do_read(32'h8000_0008, 2'd3, 8'd0, 3'd3, -1, 1'b0);
        do_read(BASE, 2'd2, 8'd2, 3'd3, -1, 1'b0);
        do_read(32'h8000_0008, 2'd1, 8'd0, 3'd4, -1, 1'b0);
        do_write(32'h8000_0050, 2'd1, 8'd1, 0, 1'b0, 1'b0, 64'd0, 8'h00);
        do_write(32'h8000_0060, 2'd1, 8'd1, -1, 1'b0, 1'b0, 64'd0, 8'h00);
        // Bursts straddling both ends of the address window.
        do_write(BASE + 32'h7FF8, 2'd1, 8'd1, 1, 1'b0, 1'b0, 64'd0, 8'h00);
        do_read(BASE + 32'h7FF8, 2'd1, 8'd1, 3'd3, -1, 1'b0);
        do_read(32'h7FFF_FFF8, 2'd1, 8'd1, 3'd3, -1, 1'b0);
        // Longest burst: 256 single-byte beats across words 0..31.
        do_read(BASE, 2'd1, 8'd255, 3'd0, -1, 1'b1);

        // Simultaneous AR and AW: the read is served first.
        araddr = 32'h8000_0008; arburst = 2'd1; arlen = 8'd0; arsize = 3'd3; arvalid = 1'b1;
        awaddr = 32'h8000_0030; awburst = 2'd1; awlen = 8'd0; awvalid = 1'b1;
        check("both_valid_arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("both_read_first_rvalid", rvalid, 1);
        check("both_read_first_wready", wready, 0);
        check("both_rdata", rdata, model[1]);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("both_awready_after_read", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        check("both_wready", wready, 1);
        wdata = 64'hDEAD_BEEF_0BAD_F00D; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        model[6] = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        check("both_bvalid", bvalid, 1);
        check("both_bresp", bresp, 0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Randomized traffic inside the preloaded region.
        for (int t = 0; t < 24; t++) begin
            rb = 2'($urandom_range(0, 2));
            rl = $urandom_range(0, 15);
            sw = $urandom_range(0, 15);
            if (rb == 2'd2) rl = (2 << $urandom_range(0, 3)) - 1;
            if ($urandom_range(0, 1) == 0) begin
                do_write(BASE + 32'(sw * 8), rb, 8'(rl), rl, 1'b1, 1'b0, 64'd0, 8'h00);
            end else begin
                rs = $urandom_range(0, 3);
                do_read(BASE + 32'(sw * 8), rb, 8'(rl), 3'(rs), -1, 1'b1);
            end
        end

        // Reset in the middle of a read burst.
        araddr = BASE; arburst = 2'd1; arlen = 8'd7; arsize = 3'd3; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rready = 1'b0;
        check("midburst_rvalid", rvalid, 1);
        rst = 1'b0;
        #1;
        all_zero("midburst_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_arready", arready, 1);
        check("post_reset_rvalid", rvalid, 0);
        do_read(32'h8000_0028, 2'd1, 8'd2, 3'd3, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
